// File: rtl/ship_place_ctrl_if.sv
// Signal bundle between the placement controller, the button debouncers,
// the occupancy RAM and the ghost-ship video overlay.
interface ship_place_ctrl_if;
    logic       start;
    logic       btn_up;
    logic       btn_down;
    logic       btn_left;
    logic       btn_right;
    logic       btn_rotate;
    logic       btn_place;
    logic [7:0] cursor;
    logic [1:0] orientation;
    logic [2:0] length;
    logic       ghost_en;
    logic [7:0] rd_addr;
    logic       rd_data;
    logic       wr_en;
    logic [7:0] wr_addr;
    logic       wr_data;
    logic [2:0] ship_idx;
    logic       place_err;
    logic       done;

    // Controller side
    modport master (
        input  start, btn_up, btn_down, btn_left, btn_right, btn_rotate, btn_place,
        input  rd_data,
        output cursor, orientation, length, ghost_en,
        output rd_addr, wr_en, wr_addr, wr_data,
        output ship_idx, place_err, done
    );

    // Environment side: buttons, RAM and overlay
    modport slave (
        output start, btn_up, btn_down, btn_left, btn_right, btn_rotate, btn_place,
        output rd_data,
        input  cursor, orientation, length, ghost_en,
        input  rd_addr, wr_en, wr_addr, wr_data,
        input  ship_idx, place_err, done
    );
endinterface

// File: rtl/ship_place_ctrl.sv
// Placement-phase sequencer for one fleet: moves the ghost ship from button
// pulses, checks bounds and overlap against the occupancy RAM, then writes
// the accepted ship into the RAM one tile per cycle.
module ship_place_ctrl #(
    parameter int GRID   = 10,
    parameter int NSHIPS = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    ship_place_ctrl_if.master bus
);

    typedef enum logic [2:0] {
        IDLE,
        AIM,
        BOUNDS,
        CHK_ADDR,
        CHK_DATA,
        WRITE,
        ERR,
        DONE
    } state_t;

    localparam logic [1:0]        NORTH = 2'd0;
    localparam logic [1:0]        EAST  = 2'd1;
    localparam logic [1:0]        SOUTH = 2'd2;
    localparam logic [1:0]        WEST  = 2'd3;
    localparam logic [3:0]        MAXC  = 4'(GRID - 1);
    localparam logic signed [4:0] MAXS  = 5'(GRID - 1);

    state_t      state_q;
    logic [3:0]  curX_q;
    logic [3:0]  curY_q;
    logic [1:0]  orient_q;
    logic [2:0]  length_q;
    logic [2:0]  shipIdx_q;
    logic [2:0]  k_q;
    logic [7:0]  rdAddr_q;
    logic [7:0]  wrAddr_q;
    logic        wrEn_q;
    logic        placeErr_q;
    logic        ghostEn_q;
    logic        done_q;

    logic signed [4:0] endX_d;
    logic signed [4:0] endY_d;
    logic signed [4:0] lenS_d;
    logic              oob_d;
    logic [2:0]        kNext_d;
    logic [2:0]        idxNext_d;
    logic [7:0]        tileNext_d;

    // Tile k of the footprint: the anchor stepped k tiles along the heading.
    // Only used once the far end is known to be on the board, so 4-bit math is safe.
    function automatic logic [7:0] stepTile(input logic [3:0] x, input logic [3:0] y,
                                            input logic [1:0] o, input logic [2:0] k);
        logic [3:0] dk;
        dk = {1'b0, k};
        case (o)
            NORTH:   stepTile = {x, y - dk};
            EAST:    stepTile = {x + dk, y};
            SOUTH:   stepTile = {x, y + dk};
            default: stepTile = {x - dk, y};
        endcase
    endfunction

    // Fleet composition: length code (size minus one) of ship idx.
    function automatic logic [2:0] lenCode(input logic [2:0] idx);
        case (idx)
            3'd0:    lenCode = 3'd4;
            3'd1:    lenCode = 3'd3;
            3'd2:    lenCode = 3'd2;
            3'd3:    lenCode = 3'd2;
            3'd4:    lenCode = 3'd1;
            default: lenCode = 3'd0;
        endcase
    endfunction

    // Far-end position in signed 5-bit so a ship hanging off either edge is seen as such.
    always_comb begin
        endX_d = signed'({1'b0, curX_q});
        endY_d = signed'({1'b0, curY_q});
        lenS_d = signed'({2'b00, length_q});
        case (orient_q)
            NORTH:   endY_d = endY_d - lenS_d;
            EAST:    endX_d = endX_d + lenS_d;
            SOUTH:   endY_d = endY_d + lenS_d;
            default: endX_d = endX_d - lenS_d;
        endcase
        oob_d      = (endX_d < 5'sd0) || (endX_d > MAXS) ||
                     (endY_d < 5'sd0) || (endY_d > MAXS);
        kNext_d    = k_q + 3'd1;
        idxNext_d  = shipIdx_q + 3'd1;
        tileNext_d = stepTile(curX_q, curY_q, orient_q, kNext_d);
    end

    // Placement FSM; every output is a register updated on the transition into its state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            curX_q     <= 4'd0;
            curY_q     <= 4'd0;
            orient_q   <= EAST;
            length_q   <= 3'd4;
            shipIdx_q  <= 3'd0;
            k_q        <= 3'd0;
            rdAddr_q   <= 8'h00;
            wrAddr_q   <= 8'h00;
            wrEn_q     <= 1'b0;
            placeErr_q <= 1'b0;
            ghostEn_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            placeErr_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        state_q   <= AIM;
                        ghostEn_q <= 1'b1;
                    end
                end
                AIM: begin
                    if (bus.btn_place) begin
                        state_q   <= BOUNDS;
                        ghostEn_q <= 1'b0;
                    end else if (bus.btn_rotate) begin
                        orient_q <= orient_q + 2'd1;
                    end else if (bus.btn_up) begin
                        if (curY_q != 4'd0) curY_q <= curY_q - 4'd1;
                    end else if (bus.btn_down) begin
                        if (curY_q != MAXC) curY_q <= curY_q + 4'd1;
                    end else if (bus.btn_left) begin
                        if (curX_q != 4'd0) curX_q <= curX_q - 4'd1;
                    end else if (bus.btn_right) begin
                        if (curX_q != MAXC) curX_q <= curX_q + 4'd1;
                    end
                end
                BOUNDS: begin
                    if (oob_d) begin
                        state_q    <= ERR;
                        placeErr_q <= 1'b1;
                    end else begin
                        state_q  <= CHK_ADDR;
                        k_q      <= 3'd0;
                        rdAddr_q <= {curX_q, curY_q};
                    end
                end
                CHK_ADDR: begin
                    state_q <= CHK_DATA;
                end
                CHK_DATA: begin
                    if (bus.rd_data) begin
                        state_q    <= ERR;
                        placeErr_q <= 1'b1;
                    end else if (k_q == length_q) begin
                        state_q  <= WRITE;
                        k_q      <= 3'd0;
                        wrEn_q   <= 1'b1;
                        wrAddr_q <= {curX_q, curY_q};
                    end else begin
                        state_q  <= CHK_ADDR;
                        k_q      <= kNext_d;
                        rdAddr_q <= tileNext_d;
                    end
                end
                WRITE: begin
                    if (k_q == length_q) begin
                        wrEn_q    <= 1'b0;
                        shipIdx_q <= idxNext_d;
                        length_q  <= lenCode(idxNext_d);
                        if (idxNext_d == 3'(NSHIPS)) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q   <= AIM;
                            ghostEn_q <= 1'b1;
                        end
                    end else begin
                        k_q      <= kNext_d;
                        wrAddr_q <= tileNext_d;
                    end
                end
                ERR: begin
                    state_q   <= AIM;
                    ghostEn_q <= 1'b1;
                end
                DONE: begin
                    state_q <= DONE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.cursor      = {curX_q, curY_q};
    assign bus.orientation = orient_q;
    assign bus.length      = length_q;
    assign bus.ghost_en    = ghostEn_q;
    assign bus.rd_addr     = rdAddr_q;
    assign bus.wr_en       = wrEn_q;
    assign bus.wr_addr     = wrAddr_q;
    assign bus.wr_data     = wrEn_q;
    assign bus.ship_idx    = shipIdx_q;
    assign bus.place_err   = placeErr_q;
    assign bus.done        = done_q;

endmodule

// File: tb/tb_ship_place_ctrl.sv
// Bench for ship_place_ctrl: a behavioural model of cursor, fleet and board
// predicts every move, read and write; expected write addresses are queued
// when a place is pressed and popped as the DUT strobes wr_en.
module tb_ship_place_ctrl;

    localparam logic [6:0] B_START = 7'b1000000;
    localparam logic [6:0] B_PLACE = 7'b0100000;
    localparam logic [6:0] B_ROT   = 7'b0010000;
    localparam logic [6:0] B_UP    = 7'b0001000;
    localparam logic [6:0] B_DOWN  = 7'b0000100;
    localparam logic [6:0] B_LEFT  = 7'b0000010;
    localparam logic [6:0] B_RIGHT = 7'b0000001;

    typedef enum {M_IDLE, M_AIM, M_BUSY, M_DONE} mstate_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    ship_place_ctrl_if ifc ();

    ship_place_ctrl #(.GRID(10), .NSHIPS(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    always #5 clk = ~clk;

    int         assertCount = 0;
    int         failCount   = 0;
    int         wrSeen      = 0;
    int         errSeen     = 0;
    int         errExp      = 0;
    logic [7:0] expWr[$];

    bit         ram[256];
    logic       presetEn   = 1'b0;
    logic [7:0] presetAddr = 8'h00;

    mstate_t    mState;
    int         mx, my, mOri, mIdx;
    logic [7:0] mRd;
    bit         mOcc[256];
    int         pL, pReject;
    bit         pOob;
    logic [7:0] pTiles[5];

    // Occupancy RAM with one-cycle read latency
    always @(posedge clk) begin
        ifc.rd_data <= ram[ifc.rd_addr];
        if (ifc.wr_en) ram[ifc.wr_addr] <= ifc.wr_data;
        if (presetEn) ram[presetAddr] <= 1'b1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assertCount++;
        if (obs !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Write scoreboard and error-pulse counter
    always @(negedge clk) begin
        if (rst_n && ifc.wr_en) begin
            wrSeen++;
            if (expWr.size() == 0) begin
                checkOutput("wr_unexpected", 32'd1, 32'd0);
            end else begin
                checkOutput("wr_addr", ifc.wr_addr, expWr.pop_front());
            end
            checkOutput("wr_data", ifc.wr_data, 1);
        end
        if (rst_n && ifc.place_err) errSeen++;
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic int lenOf(input int idx);
        int t[5];
        t = '{4, 3, 2, 2, 1};
        return (idx < 5) ? t[idx] : 0;
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic resetModel();
        mState = M_IDLE;
        mx = 0; my = 0; mOri = 1; mIdx = 0;
        mRd = 8'h00;
        expWr.delete();
    endtask

    // Predict the outcome of a place request and queue the expected writes
    task automatic modelPlace();
        int dx, dy, ex, ey, tx, ty;
        pL = lenOf(mIdx);
        dx = (mOri == 1) ? 1 : (mOri == 3) ? -1 : 0;
        dy = (mOri == 2) ? 1 : (mOri == 0) ? -1 : 0;
        ex = mx + dx * pL;
        ey = my + dy * pL;
        pOob = (ex < 0) || (ex > 9) || (ey < 0) || (ey > 9);
        pReject = -1;
        if (!pOob) begin
            for (int i = 0; i <= pL; i++) begin
                tx = mx + dx * i;
                ty = my + dy * i;
                pTiles[i] = {tx[3:0], ty[3:0]};
                if (pReject < 0 && mOcc[pTiles[i]]) pReject = i;
            end
        end
        if (pOob || pReject >= 0) begin
            errExp++;
        end else begin
            for (int i = 0; i <= pL; i++) begin
                expWr.push_back(pTiles[i]);
                mOcc[pTiles[i]] = 1'b1;
            end
            mIdx++;
        end
    endtask

    task automatic modelStep(input logic [6:0] vec);
        case (mState)
            M_IDLE: if (vec[6]) mState = M_AIM;
            M_AIM: begin
                if (vec[5]) begin
                    modelPlace();
                    mState = M_BUSY;
                end else if (vec[4]) mOri = (mOri + 1) % 4;
                else if (vec[3]) my = (my > 0) ? my - 1 : 0;
                else if (vec[2]) my = (my < 9) ? my + 1 : 9;
                else if (vec[1]) mx = (mx > 0) ? mx - 1 : 0;
                else if (vec[0]) mx = (mx < 9) ? mx + 1 : 9;
            end
            default: ;
        endcase
    endtask

    task automatic checkAim();
        checkOutput("cursor", ifc.cursor, {mx[3:0], my[3:0]});
        checkOutput("orientation", ifc.orientation, mOri);
        checkOutput("ghost_en", ifc.ghost_en, (mState == M_AIM));
        checkOutput("done", ifc.done, (mState == M_DONE));
    endtask

    // Drive one cycle of button pulses; returns on the following negedge
    task automatic applyStimulus(input logic [6:0] vec);
        {ifc.start, ifc.btn_place, ifc.btn_rotate, ifc.btn_up,
         ifc.btn_down, ifc.btn_left, ifc.btn_right} = vec;
        modelStep(vec);
        tick();
        {ifc.start, ifc.btn_place, ifc.btn_rotate, ifc.btn_up,
         ifc.btn_down, ifc.btn_left, ifc.btn_right} = 7'b0;
        if (mState != M_BUSY) checkAim();
    endtask

    task automatic pressN(input logic [6:0] vec, input int n);
        for (int i = 0; i < n; i++) applyStimulus(vec);
    endtask

    task automatic checkReset();
        checkOutput("rst_cursor", ifc.cursor, 8'h00);
        checkOutput("rst_orientation", ifc.orientation, 2'd1);
        checkOutput("rst_length", ifc.length, 3'd4);
        checkOutput("rst_ship_idx", ifc.ship_idx, 3'd0);
        checkOutput("rst_ghost_en", ifc.ghost_en, 1'b0);
        checkOutput("rst_wr_en", ifc.wr_en, 1'b0);
        checkOutput("rst_place_err", ifc.place_err, 1'b0);
        checkOutput("rst_done", ifc.done, 1'b0);
        checkOutput("rst_rd_addr", ifc.rd_addr, 8'h00);
        checkOutput("rst_wr_addr", ifc.wr_addr, 8'h00);
    endtask

    // Follow a place request cycle by cycle from the BOUNDS cycle onwards
    task automatic followPlacement(input bit rotDuringWrite);
        int n;
        checkOutput("bounds_no_err", ifc.place_err, 1'b0);
        if (pOob) begin
            tick();
            checkOutput("oob_err_pulse", ifc.place_err, 1'b1);
            checkOutput("oob_rd_idle", ifc.rd_addr, mRd);
            checkOutput("oob_no_wr", ifc.wr_en, 1'b0);
            tick();
            checkOutput("err_one_cycle", ifc.place_err, 1'b0);
            mState = M_AIM;
        end else begin
            n = (pReject >= 0) ? pReject : pL;
            for (int i = 0; i <= n; i++) begin
                tick();
                checkOutput("chk_rd_addr", ifc.rd_addr, pTiles[i]);
                tick();
            end
            mRd = pTiles[n];
            tick();
            if (pReject >= 0) begin
                checkOutput("reject_err", ifc.place_err, 1'b1);
                checkOutput("reject_no_wr", ifc.wr_en, 1'b0);
                tick();
                checkOutput("err_one_cycle", ifc.place_err, 1'b0);
                mState = M_AIM;
            end else begin
                checkOutput("write_start", ifc.wr_en, 1'b1);
                for (int i = 0; i <= pL; i++) begin
                    if (i == 0 && rotDuringWrite) ifc.btn_rotate = 1'b1;
                    tick();
                    ifc.btn_rotate = 1'b0;
                end
                mState = (mIdx == 5) ? M_DONE : M_AIM;
                checkOutput("write_end", ifc.wr_en, 1'b0);
                checkOutput("ship_idx", ifc.ship_idx, mIdx);
                if (mState == M_AIM) checkOutput("next_length", ifc.length, lenOf(mIdx));
            end
        end
        checkAim();
    endtask

    initial begin
        int cnt;
        {ifc.start, ifc.btn_place, ifc.btn_rotate, ifc.btn_up,
         ifc.btn_down, ifc.btn_left, ifc.btn_right} = 7'b0;
        resetModel();
        repeat (3) tick();
        checkReset();
        rst_n = 1'b1;
        tick();

        $display("[TB] buttons ignored in IDLE, then start");
        applyStimulus(B_RIGHT);
        applyStimulus(B_START);

        $display("[TB] saturation at the top-left corner");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(B_UP);
            applyStimulus(B_LEFT);
        end

        $display("[TB] NORTH ship of length 5 from 0x01 is out of bounds");
        applyStimulus(B_DOWN);
        pressN(B_ROT, 3);
        applyStimulus(B_PLACE);
        followPlacement(1'b0);

        $display("[TB] ship 0 EAST from 0x32");
        applyStimulus(B_ROT);
        pressN(B_RIGHT, 3);
        applyStimulus(B_DOWN);
        applyStimulus(B_PLACE);
        followPlacement(1'b0);

        $display("[TB] saturation at the bottom-right corner");
        for (int i = 0; i < 10; i++) begin
            applyStimulus(B_DOWN);
            applyStimulus(B_RIGHT);
        end

        $display("[TB] EAST ship from 0x99 overhangs the right edge");
        applyStimulus(B_PLACE);
        followPlacement(1'b0);

        $display("[TB] overlap with preset tile 0x54 rejected on the last read");
        presetEn   = 1'b1;
        presetAddr = 8'h54;
        mOcc[8'h54] = 1'b1;
        tick();
        presetEn = 1'b0;
        pressN(B_UP, 5);
        pressN(B_LEFT, 7);
        applyStimulus(B_PLACE);
        followPlacement(1'b0);

        $display("[TB] place beats right in the same cycle, rotate dropped during write");
        pressN(B_DOWN, 2);
        applyStimulus(B_PLACE | B_RIGHT);
        followPlacement(1'b1);

        $display("[TB] remaining ships, one ending exactly on the right edge");
        applyStimulus(B_DOWN);
        pressN(B_RIGHT, 5);
        applyStimulus(B_PLACE);
        followPlacement(1'b0);
        pressN(B_LEFT, 5);
        applyStimulus(B_DOWN);
        applyStimulus(B_PLACE);
        followPlacement(1'b0);
        applyStimulus(B_DOWN);
        applyStimulus(B_PLACE);
        followPlacement(1'b0);
        checkOutput("fleet_writes", wrSeen, 17);
        checkOutput("scoreboard_empty", expWr.size(), 0);

        $display("[TB] inputs ignored once done");
        applyStimulus(B_START);
        applyStimulus(B_RIGHT);
        applyStimulus(B_ROT);
        applyStimulus(B_PLACE);
        pressN(7'b0, 3);
        checkOutput("done_no_writes", wrSeen, 17);
        checkOutput("err_pulses", errSeen, errExp);

        $display("[TB] reset in the middle of a write");
        rst_n = 1'b0;
        tick();
        tick();
        resetModel();
        checkReset();
        rst_n = 1'b1;
        tick();
        applyStimulus(B_START);
        applyStimulus(B_PLACE);
        cnt = 0;
        while (!ifc.wr_en && cnt < 40) begin
            tick();
            cnt++;
        end
        checkOutput("rst_test_latency", cnt, 11);
        tick();
        #2 rst_n = 1'b0;
        #1;
        expWr.delete();
        checkReset();
        tick();
        rst_n = 1'b1;
        tick();
        checkOutput("post_rst_idle_ghost", ifc.ghost_en, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
